// File: rtl/key_conditioner.sv
// Key input conditioner: synchronises raw active-low buttons, debounces each key with a
// shared tick prescaler and a per-key FSM, and emits clean levels, edge pulses and toggle bits.
module key_conditioner #(
   parameter int unsigned N_KEYS       = 4,
   parameter int unsigned TICK_DIV     = 16,
   parameter int unsigned STABLE_TICKS = 4
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic [N_KEYS-1:0] KEY_SW,
   output logic [N_KEYS-1:0] key_level,
   output logic [N_KEYS-1:0] key_press,
   output logic [N_KEYS-1:0] key_release,
   output logic [N_KEYS-1:0] key_toggle,
   output logic              tick
);

   localparam int unsigned      CNT_W    = $clog2(STABLE_TICKS + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

   typedef enum logic [1:0] {
      RELEASED     = 2'd0,
      PRESS_WAIT   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_WAIT = 2'd3
   } state_t;

   logic [N_KEYS-1:0]   sync1;
   logic [N_KEYS-1:0]   sync2;
   logic [N_KEYS-1:0]   p;
   logic [TICK_DIV-1:0] presc;

   state_t              state     [N_KEYS];
   state_t              state_nxt [N_KEYS];
   logic [CNT_W-1:0]    cnt       [N_KEYS];
   logic [CNT_W-1:0]    cnt_nxt   [N_KEYS];
   logic [N_KEYS-1:0]   level_nxt;
   logic [N_KEYS-1:0]   press_nxt;
   logic [N_KEYS-1:0]   release_nxt;

   assign p    = ~sync2;
   assign tick = &presc;

   // Synchroniser and free-running tick prescaler
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         sync1 <= '1;
         sync2 <= '1;
         presc <= '0;
      end else begin
         sync1 <= KEY_SW;
         sync2 <= sync1;
         presc <= presc + TICK_DIV'(1);
      end
   end

   // Per-key FSM and counter state registers plus registered outputs
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         for (int i = 0; i < N_KEYS; i++) begin
            state[i] <= RELEASED;
            cnt[i]   <= '0;
         end
         key_level   <= '0;
         key_press   <= '0;
         key_release <= '0;
         key_toggle  <= '0;
      end else begin
         for (int i = 0; i < N_KEYS; i++) begin
            state[i] <= state_nxt[i];
            cnt[i]   <= cnt_nxt[i];
         end
         key_level   <= level_nxt;
         key_press   <= press_nxt;
         key_release <= release_nxt;
         key_toggle  <= key_toggle ^ press_nxt;
      end
   end

   // Next-state: a bounce reverts the state and takes priority over a coincident tick
   always_comb begin
      level_nxt   = '0;
      press_nxt   = '0;
      release_nxt = '0;
      for (int i = 0; i < N_KEYS; i++) begin
         state_nxt[i] = state[i];
         cnt_nxt[i]   = cnt[i];
         case (state[i])
            RELEASED: begin
               if (p[i]) begin
                  state_nxt[i] = PRESS_WAIT;
                  cnt_nxt[i]   = '0;
               end
            end
            PRESS_WAIT: begin
               if (!p[i]) begin
                  state_nxt[i] = RELEASED;
                  cnt_nxt[i]   = '0;
               end else if (tick) begin
                  if (cnt[i] == CNT_LAST) begin
                     state_nxt[i] = PRESSED;
                     cnt_nxt[i]   = '0;
                  end else begin
                     cnt_nxt[i] = cnt[i] + CNT_W'(1);
                  end
               end
            end
            PRESSED: begin
               if (!p[i]) begin
                  state_nxt[i] = RELEASE_WAIT;
                  cnt_nxt[i]   = '0;
               end
            end
            RELEASE_WAIT: begin
               if (p[i]) begin
                  state_nxt[i] = PRESSED;
                  cnt_nxt[i]   = '0;
               end else if (tick) begin
                  if (cnt[i] == CNT_LAST) begin
                     state_nxt[i] = RELEASED;
                     cnt_nxt[i]   = '0;
                  end else begin
                     cnt_nxt[i] = cnt[i] + CNT_W'(1);
                  end
               end
            end
            default: begin
               state_nxt[i] = RELEASED;
               cnt_nxt[i]   = '0;
            end
         endcase
         level_nxt[i]   = (state_nxt[i] == PRESSED) || (state_nxt[i] == RELEASE_WAIT);
         press_nxt[i]   = (state[i] == PRESS_WAIT) && (state_nxt[i] == PRESSED);
         release_nxt[i] = (state[i] == RELEASE_WAIT) && (state_nxt[i] == RELEASED);
      end
   end

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner: directed scenarios plus randomized bouncy keys, each cycle checked
// against a tick-counting debounce model.
module tb_key_conditioner;

   localparam int NK  = 4;
   localparam int TD  = 2;
   localparam int ST  = 3;
   localparam int PER = 1 << TD;

   logic          CLK;
   logic          RESET;
   logic [NK-1:0] KEY_SW;
   logic [NK-1:0] key_level;
   logic [NK-1:0] key_press;
   logic [NK-1:0] key_release;
   logic [NK-1:0] key_toggle;
   logic          tick;

   key_conditioner #(.N_KEYS(NK), .TICK_DIV(TD), .STABLE_TICKS(ST)) dut (
      .CLK(CLK), .RESET(RESET), .KEY_SW(KEY_SW),
      .key_level(key_level), .key_press(key_press), .key_release(key_release),
      .key_toggle(key_toggle), .tick(tick)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int n_vec = 0;
   int n_err = 0;
   int edge_n = 0;

   // Reference model: debounced level per key, plus how many ticks the disagreement has lasted
   int            m_cyc = 0;
   logic [NK-1:0] m_s1 = '1;
   logic [NK-1:0] m_s2 = '1;
   logic [NK-1:0] m_level = '0;
   logic [NK-1:0] m_press = '0;
   logic [NK-1:0] m_release = '0;
   logic [NK-1:0] m_toggle = '0;
   bit            m_wait [NK];
   int            m_ticks [NK];

   function automatic logic [4*NK:0] model_vec();
      logic tk;
      tk = ((m_cyc % PER) == PER - 1);
      return {tk, m_level, m_press, m_release, m_toggle};
   endfunction

   function automatic logic [4*NK:0] dut_vec();
      return {tick, key_level, key_press, key_release, key_toggle};
   endfunction

   task automatic step();
      bit            tk;
      logic [NK-1:0] pu;
      @(posedge CLK);
      edge_n++;
      tk = ((m_cyc % PER) == PER - 1);
      pu = ~m_s2;
      if (!RESET) begin
         m_cyc = 0;
         m_s1 = '1; m_s2 = '1;
         m_level = '0; m_press = '0; m_release = '0; m_toggle = '0;
         for (int k = 0; k < NK; k++) begin m_wait[k] = 0; m_ticks[k] = 0; end
      end else begin
         m_cyc++;
         m_s2 = m_s1;
         m_s1 = KEY_SW;
         m_press = '0;
         m_release = '0;
         for (int k = 0; k < NK; k++) begin
            if (pu[k] == m_level[k]) begin
               m_wait[k] = 0; m_ticks[k] = 0;
            end else if (!m_wait[k]) begin
               m_wait[k] = 1; m_ticks[k] = 0;
            end else if (tk) begin
               m_ticks[k]++;
               if (m_ticks[k] == ST) begin
                  m_level[k] = ~m_level[k];
                  if (m_level[k]) begin
                     m_press[k] = 1'b1;
                     m_toggle[k] = ~m_toggle[k];
                  end else begin
                     m_release[k] = 1'b1;
                  end
                  m_wait[k] = 0; m_ticks[k] = 0;
               end
            end
         end
      end
      #1;
   endtask

   task automatic test_reset();
      RESET = 1'b0;
      KEY_SW = '1;
      repeat (3) begin
         step();
         n_vec++;
         if (dut_vec() !== '0) begin
            n_err++;
            $display("FAIL reset_zero: got %h want %h", dut_vec(), 17'h0);
         end
      end
      RESET = 1'b1;
   endtask

   task automatic test_idle();
      int first_tick = -1;
      int n_ticks = 0;
      for (int c = 1; c <= 50; c++) begin
         step();
         n_vec++;
         if (dut_vec() !== model_vec()) begin
            n_err++;
            $display("FAIL idle c%0d: got %h want %h", c, dut_vec(), model_vec());
         end
         if (tick === 1'b1) begin
            n_ticks++;
            if (first_tick < 0) first_tick = c + 1;
         end
      end
      n_vec++;
      if (first_tick !== 4) begin
         n_err++;
         $display("FAIL first_tick: got cycle %0d want cycle 4", first_tick);
      end
      n_vec++;
      if (n_ticks !== 12) begin
         n_err++;
         $display("FAIL tick_rate: got %0d ticks want 12", n_ticks);
      end
   endtask

   task automatic test_press();
      int p_edge = -1;
      int rise_edge = -1;
      int presses = 0;
      KEY_SW[1] = 1'b0;
      for (int c = 0; c < 25; c++) begin
         step();
         n_vec++;
         if (dut_vec() !== model_vec()) begin
            n_err++;
            $display("FAIL press c%0d: got %h want %h", c, dut_vec(), model_vec());
         end
         if (!m_s2[1] && p_edge < 0) p_edge = edge_n + 1;
         if (key_level[1] === 1'b1 && rise_edge < 0) rise_edge = edge_n;
         if (key_press[1] === 1'b1) presses++;
      end
      n_vec++;
      if (rise_edge < 0 || rise_edge - p_edge < 9 || rise_edge - p_edge > 12) begin
         n_err++;
         $display("FAIL press_latency: got %0d cycles want 9..12", rise_edge - p_edge);
      end
      n_vec++;
      if (presses !== 1) begin
         n_err++;
         $display("FAIL press_count: got %0d want 1", presses);
      end
      n_vec++;
      if (key_toggle[1] !== 1'b1) begin
         n_err++;
         $display("FAIL press_toggle: got %b want 1", key_toggle[1]);
      end
   endtask

   task automatic test_release();
      int rels = 0;
      KEY_SW[1] = 1'b1;
      for (int c = 0; c < 25; c++) begin
         step();
         n_vec++;
         if (dut_vec() !== model_vec()) begin
            n_err++;
            $display("FAIL release c%0d: got %h want %h", c, dut_vec(), model_vec());
         end
         if (key_release[1] === 1'b1) rels++;
      end
      n_vec++;
      if (rels !== 1 || key_level[1] !== 1'b0 || key_toggle[1] !== 1'b1) begin
         n_err++;
         $display("FAIL release_end: got rel=%0d lvl=%b tog=%b want 1 0 1", rels, key_level[1],
                  key_toggle[1]);
      end
   endtask

   task automatic test_glitch();
      int presses = 0;
      int highs = 0;
      for (int c = 0; c < 26; c++) begin
         KEY_SW[1] = (c < 6) ? ((c % 2) == 0 ? 1'b0 : 1'b1) : 1'b1;
         step();
         n_vec++;
         if (dut_vec() !== model_vec()) begin
            n_err++;
            $display("FAIL glitch c%0d: got %h want %h", c, dut_vec(), model_vec());
         end
         if (key_press[1] === 1'b1) presses++;
         if (key_level[1] !== 1'b0) highs++;
      end
      n_vec++;
      if (presses !== 0 || highs !== 0) begin
         n_err++;
         $display("FAIL glitch_ignored: got presses=%0d level_high=%0d want 0 0", presses, highs);
      end
   endtask

   task automatic test_simultaneous();
      logic [NK-1:0] first_press = '0;
      RESET = 1'b0;
      repeat (2) step();
      RESET = 1'b1;
      for (int ph = 0; ph < 4; ph++) begin
         case (ph)
            0: KEY_SW = 4'h0;
            1: KEY_SW = 4'hF;
            2: KEY_SW = 4'hE;
            default: KEY_SW = 4'hF;
         endcase
         for (int c = 0; c < 25; c++) begin
            step();
            n_vec++;
            if (dut_vec() !== model_vec()) begin
               n_err++;
               $display("FAIL simul p%0d c%0d: got %h want %h", ph, c, dut_vec(), model_vec());
            end
            if (ph == 0 && first_press == '0) first_press = key_press;
         end
      end
      n_vec++;
      if (first_press !== 4'hF) begin
         n_err++;
         $display("FAIL simul_press: got %h want f", first_press);
      end
      n_vec++;
      if (key_toggle !== 4'hE) begin
         n_err++;
         $display("FAIL simul_toggle: got %h want e", key_toggle);
      end
   endtask

   task automatic test_reset_mid();
      int presses = 0;
      int guard = 0;
      KEY_SW = 4'hB;
      while (!m_wait[2] && guard < 8) begin
         step();
         guard++;
      end
      n_vec++;
      if (!m_wait[2]) begin
         n_err++;
         $display("FAIL midreset_reach: got no wait after %0d cycles want wait", guard);
      end
      step();
      RESET = 1'b0;
      repeat (2) step();
      n_vec++;
      if (dut_vec() !== model_vec() || key_level !== '0 || key_toggle !== '0) begin
         n_err++;
         $display("FAIL midreset_clear: got %h want %h", dut_vec(), model_vec());
      end
      RESET = 1'b1;
      for (int c = 0; c < 30; c++) begin
         step();
         n_vec++;
         if (dut_vec() !== model_vec()) begin
            n_err++;
            $display("FAIL midreset c%0d: got %h want %h", c, dut_vec(), model_vec());
         end
         if (key_press[2] === 1'b1) presses++;
      end
      n_vec++;
      if (presses !== 1) begin
         n_err++;
         $display("FAIL midreset_press: got %0d want 1", presses);
      end
      KEY_SW = 4'hF;
      repeat (20) step();
   endtask

   task automatic test_random();
      logic [NK-1:0] tgt = '1;
      for (int c = 0; c < 2500; c++) begin
         for (int k = 0; k < NK; k++) begin
            if ($urandom_range(39) == 0) tgt[k] = ~tgt[k];
            KEY_SW[k] = ($urandom_range(7) == 0) ? ~tgt[k] : tgt[k];
         end
         RESET = ($urandom_range(599) != 0);
         step();
         n_vec++;
         if (dut_vec() !== model_vec()) begin
            n_err++;
            $display("FAIL random c%0d: got %h want %h", c, dut_vec(), model_vec());
         end
      end
      RESET = 1'b1;
   endtask

   initial begin
      RESET = 1'b0;
      KEY_SW = '1;
      test_reset();
      test_idle();
      test_press();
      test_release();
      test_glitch();
      test_simultaneous();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
